wb_gpio_irq: RTL and testbench

Parametrised Wishbone GPIO controller, successor to the fixed 8-bit gpio0 port of the picorv32 Wishbone SoC. Drives `WIDTH` bidirectional pins (LEDs, KEYs, IO header) with per-pin direction and per-pin edge interrupts. Presents one combined interrupt line to the CPU. Sits on the SoC Wishbone bus in the `wb_clk` domain; the board top owns the tristate pads.

---
 rtl/wb_gpio_irq.sv | 97 +++++++++
 tb/tb_wb_gpio_irq.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/wb_gpio_irq.sv
// wb_gpio_irq: Wishbone GPIO (IN/OUT/DIR/IE/POL/IS) with per-pin edge irq; GPIO_DEBOUNCE_EN adds per-pin input debounce
module wb_gpio_irq #(
  parameter int WIDTH = 8,
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_n_i,
  input  logic [4:0]       wb_adr_i,
  input  logic [31:0]      wb_dat_i,
  input  logic [3:0]       wb_sel_i,
  input  logic             wb_we_i,
  input  logic             wb_cyc_i,
  input  logic             wb_stb_i,
  output logic [31:0]      wb_dat_o,
  output logic             wb_ack_o,
  input  logic [WIDTH-1:0] gpio_i,
  output logic [WIDTH-1:0] gpio_o,
  output logic [WIDTH-1:0] gpio_dir_o,
  output logic             irq_o
);
  logic [WIDTH-1:0] out_r, dir_r, ie_r, pol_r, is_r, s1, s2, prev, val, set, m, d, clr;
  logic [31:0] bm, rd;
  logic [1:0] wcnt;
  logic warm, req, wr, unused;
  assign warm = &wcnt;
  assign req = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign wr = req & wb_we_i;
  assign bm = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}}, {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
  assign m = bm[WIDTH-1:0];
  assign d = wb_dat_i[WIDTH-1:0];
  assign set = warm ? ((pol_r & val & ~prev) | (~pol_r & ~val & prev)) : '0;
  assign clr = (wr && wb_adr_i[4:2] == 3'd5) ? (d & m) : '0;
  assign irq_o = |(is_r & ie_r);
  assign gpio_o = out_r;
  assign gpio_dir_o = dir_r;
  assign unused = &{1'b0, wb_adr_i[1:0], wb_dat_i, bm, DEBOUNCE_CYCLES};
  always_comb begin
    case (wb_adr_i[4:2])
      3'd0: rd = 32'(val);
      3'd1: rd = 32'(out_r);
      3'd2: rd = 32'(dir_r);
      3'd3: rd = 32'(ie_r);
      3'd4: rd = 32'(pol_r);
      3'd5: rd = 32'(is_r);
      default: rd = '0;
    endcase
  end
`ifdef GPIO_DEBOUNCE_EN
  logic [WIDTH-1:0] filt;
  logic [15:0] dcnt [WIDTH];
  assign val = filt;
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      filt <= '0;
      for (int i = 0; i < WIDTH; i++) dcnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (!warm || s2[i] == filt[i] || dcnt[i] == DEBOUNCE_CYCLES - 16'd1) begin
          filt[i] <= s2[i];
          dcnt[i] <= '0;
        end else begin
          dcnt[i] <= dcnt[i] + 16'd1;
        end
      end
    end
  end
`else
  assign val = s2;
`endif
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
      wcnt <= '0;
      s1 <= '0;
      s2 <= '0;
      prev <= '0;
      out_r <= '0;
      dir_r <= '0;
      ie_r <= '0;
      pol_r <= '0;
      is_r <= '0;
    end else begin
      wb_ack_o <= req;
      wb_dat_o <= req ? rd : '0;
      wcnt <= wcnt + {1'b0, ~warm};
      s1 <= gpio_i;
      s2 <= s1;
      prev <= warm ? val : s2;
      if (wr && wb_adr_i[4:2] == 3'd1) out_r <= (out_r & ~m) | (d & m);
      if (wr && wb_adr_i[4:2] == 3'd2) dir_r <= (dir_r & ~m) | (d & m);
      if (wr && wb_adr_i[4:2] == 3'd3) ie_r <= (ie_r & ~m) | (d & m);
      if (wr && wb_adr_i[4:2] == 3'd4) pol_r <= (pol_r & ~m) | (d & m);
      is_r <= (is_r & ~clr) | set;
    end
  end
endmodule

// File: tb/tb_wb_gpio_irq.sv
// tb_wb_gpio_irq: directed scoreboard bench for wb_gpio_irq
module tb_wb_gpio_irq;
  localparam int W = 8;
`ifdef GPIO_DEBOUNCE_EN
  localparam int XL = 4;
  localparam logic [15:0] DC = 16'd4;
`else
  localparam int XL = 0;
  localparam logic [15:0] DC = 16'd50000;
`endif
  logic clk, rst_n, we, cyc, stb, ack, irq;
  logic [4:0] adr;
  logic [31:0] dat_i, dat_o;
  logic [3:0] sel;
  logic [W-1:0] gpio_i, gpio_o, gpio_dir;
  logic [W-1:0] cap_o, cap_dir;
  logic [31:0] sb [$];
  int n_run, n_fail;
  wb_gpio_irq #(.WIDTH(W), .DEBOUNCE_CYCLES(DC)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .wb_adr_i(adr), .wb_dat_i(dat_i),
    .wb_sel_i(sel), .wb_we_i(we), .wb_cyc_i(cyc), .wb_stb_i(stb),
    .wb_dat_o(dat_o), .wb_ack_o(ack), .gpio_i(gpio_i), .gpio_o(gpio_o),
    .gpio_dir_o(gpio_dir), .irq_o(irq)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic bus(input logic w, input logic [4:0] a, input logic [31:0] dt, input logic [3:0] s, input string tag);
    int k;
    logic [31:0] e;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_i = dt; sel = s;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!ack && k < 4);
    chk({tag, "_ack"}, 32'(ack), 32'd1);
    cap_o = gpio_o;
    cap_dir = gpio_dir;
    if (!w) begin
      e = (sb.size() > 0) ? sb.pop_front() : 32'hDEAD_BEEF;
      chk(tag, dat_o, e);
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(negedge clk);
    chk({tag, "_ack1w"}, 32'(ack), 32'd0);
    chk({tag, "_dat0"}, dat_o, 32'd0);
  endtask
  task automatic rd(input logic [4:0] a, input logic [31:0] exp, input string tag);
    sb.push_back(exp);
    bus(1'b0, a, 32'd0, 4'hF, tag);
  endtask
  task automatic wrt(input logic [4:0] a, input logic [31:0] dt, input logic [3:0] s, input string tag);
    bus(1'b1, a, dt, s, tag);
  endtask
  initial begin
    n_run = 0; n_fail = 0;
    rst_n = 1'b0; we = 1'b0; cyc = 1'b0; stb = 1'b0; adr = '0; dat_i = '0; sel = '0; gpio_i = '0;
    wait_n(3);
    chk("rst_gpio_o", 32'(gpio_o), 32'd0);
    chk("rst_dir", 32'(gpio_dir), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_dat", dat_o, 32'd0);
    rst_n = 1'b1;
    for (int a = 0; a < 8; a++) rd(5'(a * 4), 32'd0, "rst_rd");
    wrt(5'h04, 32'h0000_00A5, 4'b0001, "wr_out");
    chk("out_in_ack", 32'(cap_o), 32'hA5);
    wrt(5'h08, 32'h0000_000F, 4'hF, "wr_dir");
    chk("dir_in_ack", 32'(cap_dir), 32'h0F);
    wrt(5'h04, 32'hFFFF_FF00, 4'b0010, "wr_out_sel");
    rd(5'h04, 32'hA5, "rd_out");
    rd(5'h08, 32'h0F, "rd_dir");
    chk("gpio_o_kept", 32'(gpio_o), 32'hA5);
    wrt(5'h0C, 32'h01, 4'hF, "wr_ie");
    wrt(5'h10, 32'h01, 4'hF, "wr_pol");
    gpio_i[0] = 1'b1;
    wait_n(2 + XL);
    chk("irq_early", 32'(irq), 32'd0);
    wait_n(1);
    chk("irq_rise", 32'(irq), 32'd1);
    rd(5'h14, 32'h01, "is_rise");
    rd(5'h00, 32'h01, "in_rise");
    wrt(5'h14, 32'h01, 4'h1, "w1c");
    chk("irq_cleared", 32'(irq), 32'd0);
    rd(5'h14, 32'h00, "is_cleared");
    gpio_i[0] = 1'b0;
    wait_n(5 + XL);
    chk("irq_fall", 32'(irq), 32'd0);
    rd(5'h14, 32'h00, "is_fall");
    gpio_i[3] = 1'b1;
    wait_n(5 + XL);
    gpio_i[3] = 1'b0;
    wait_n(5 + XL);
    rd(5'h14, 32'h08, "is_noie");
    chk("irq_noie", 32'(irq), 32'd0);
    wrt(5'h14, 32'h08, 4'b0000, "w1c_nosel");
    rd(5'h14, 32'h08, "is_nosel");
    wrt(5'h10, 32'h05, 4'hF, "wr_pol2");
    gpio_i[2] = 1'b1;
    wait_n(5 + XL);
    rd(5'h14, 32'h0C, "is_b2");
    gpio_i[2] = 1'b0;
    wait_n(5 + XL);
    gpio_i[2] = 1'b1;
    wait_n(2 + XL);
    wrt(5'h14, 32'h04, 4'h1, "w1c_collide");
    rd(5'h14, 32'h0C, "is_collide");
    wrt(5'h14, 32'hFF, 4'hF, "w1c_all");
    rd(5'h14, 32'h00, "is_all_clr");
    wrt(5'h18, 32'hFFFF_FFFF, 4'hF, "wr_unmap");
    rd(5'h18, 32'h00, "rd_18");
    rd(5'h1C, 32'h00, "rd_1c");
`ifdef GPIO_DEBOUNCE_EN
    wrt(5'h10, 32'h25, 4'hF, "db_pol");
    wrt(5'h0C, 32'h20, 4'hF, "db_ie");
    gpio_i[5] = 1'b1;
    wait_n(3);
    gpio_i[5] = 1'b0;
    wait_n(10);
    rd(5'h00, 32'h04, "db_glitch_in");
    rd(5'h14, 32'h00, "db_glitch_is");
    gpio_i[5] = 1'b1;
    wait_n(6);
    chk("db_irq_early", 32'(irq), 32'd0);
    wait_n(1);
    chk("db_irq", 32'(irq), 32'd1);
    rd(5'h00, 32'h24, "db_in");
`endif
    gpio_i = '1;
    rst_n = 1'b0;
    #1;
    chk("rst2_irq", 32'(irq), 32'd0);
    chk("rst2_ack", 32'(ack), 32'd0);
    wait_n(2);
    rst_n = 1'b1;
    wait_n(6 + XL);
    rd(5'h14, 32'h00, "warm_is");
    rd(5'h00, 32'hFF, "warm_in");
    rd(5'h0C, 32'h00, "warm_ie");
    wrt(5'h0C, 32'hFF, 4'hF, "warm_wr_ie");
    chk("warm_irq", 32'(irq), 32'd0);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 5'h04; dat_i = 32'h55; sel = 4'hF;
    @(posedge clk);
    #1;
    chk("mid_ack", 32'(ack), 32'd1);
    chk("mid_out", 32'(gpio_o), 32'h55);
    rst_n = 1'b0;
    #1;
    chk("mid_ack_drop", 32'(ack), 32'd0);
    chk("mid_out_rst", 32'(gpio_o), 32'h00);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    wait_n(2);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
